// File: rtl/cia_sp_peer.sv
// Far-end partner for the CIA serial port: receives bytes on CNT/SP and transmits by driving CNT/SP itself.
// Define CIA_SP_PEER_FIFO_EN for a 4-entry TX FIFO; otherwise a single holding register is used.
module cia_sp_peer #(
    parameter int HALF_DIV   = 16,
    parameter int RX_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       txmode,
    input  logic       cnt_in,
    input  logic       sp_in,
    output logic       cnt_out,
    output logic       sp_out,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_ovr
);

    localparam logic [7:0]  DIV_LAST = 8'(HALF_DIV - 1);
    localparam logic [15:0] TO_LAST  = 16'(RX_TIMEOUT - 1);
    localparam bit          TO_EN    = (RX_TIMEOUT != 0);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} tx_state_t;

    tx_state_t   state, state_next;
    logic        cnt_s1, cnt_s2, cnt_s3, sp_s1, sp_s2;
    logic        txmode_q, mode_chg, cnt_rise;
    logic        push, pop, load, shift;
    logic        st_full, st_empty;
    logic [7:0]  st_head;
    logic [7:0]  sr, div_cnt;
    logic [2:0]  bit_cnt;
    logic        half_end;
    logic [7:0]  rx_sr, rx_byte;
    logic [2:0]  rx_cnt;
    logic [15:0] to_cnt;
    logic        byte_done;

    // Synchronizers reset to the released level so idle pads never look like an edge.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_s1   <= 1'b1;
            cnt_s2   <= 1'b1;
            cnt_s3   <= 1'b1;
            sp_s1    <= 1'b1;
            sp_s2    <= 1'b1;
            txmode_q <= 1'b0;
        end else begin
            cnt_s1   <= cnt_in;
            cnt_s2   <= cnt_s1;
            cnt_s3   <= cnt_s2;
            sp_s1    <= sp_in;
            sp_s2    <= sp_s1;
            txmode_q <= txmode;
        end
    end

    assign cnt_rise = cnt_s2 & ~cnt_s3;
    assign mode_chg = txmode ^ txmode_q;
    // Gating with txmode_q keeps tx_ready low in reset and in the flush cycle.
    assign tx_ready = txmode & txmode_q & ~st_full;
    assign push     = tx_valid & tx_ready;

`ifdef CIA_SP_PEER_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] rd_ptr, wr_ptr;
    logic [2:0] fifo_cnt;

    assign st_full  = (fifo_cnt == 3'd4);
    assign st_empty = (fifo_cnt == 3'd0);
    assign st_head  = fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (mode_chg) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= tx_data;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
`else
    logic [7:0] hold_data;
    logic       hold_valid;

    assign st_full  = hold_valid;
    assign st_empty = ~hold_valid;
    assign st_head  = hold_data;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (mode_chg) begin
            hold_valid <= 1'b0;
        end else if (push) begin
            hold_data  <= tx_data;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    assign half_end = (div_cnt == DIV_LAST);
    assign tx_busy  = (state != S_IDLE);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        pop        = 1'b0;
        shift      = 1'b0;
        cnt_out    = 1'b1;
        sp_out     = 1'b1;
        case (state)
            S_LOW: begin
                cnt_out = 1'b0;
                sp_out  = sr[7];
            end
            S_HIGH:  sp_out = sr[7];
            default: ;
        endcase
        if (mode_chg) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (txmode && !st_empty) begin
                        load       = 1'b1;
                        pop        = 1'b1;
                        state_next = S_LOW;
                    end
                end
                S_LOW: begin
                    if (half_end) state_next = S_HIGH;
                end
                S_HIGH: begin
                    if (half_end) begin
                        shift = 1'b1;
                        if (bit_cnt != 3'd7) begin
                            state_next = S_LOW;
                        end else if (txmode && !st_empty) begin
                            load       = 1'b1;
                            pop        = 1'b1;
                            state_next = S_LOW;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sr      <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sr      <= st_head;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (mode_chg || state == S_IDLE) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (half_end) begin
            div_cnt <= '0;
            if (shift) begin
                sr      <= {sr[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // Completed bytes are captured in rx_byte and committed one cycle later.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            rx_sr     <= '0;
            rx_byte   <= '0;
            rx_cnt    <= '0;
            to_cnt    <= '0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (mode_chg) begin
                rx_cnt <= '0;
                to_cnt <= '0;
            end else if (!txmode && cnt_rise) begin
                rx_sr  <= {rx_sr[6:0], sp_s2};
                rx_cnt <= rx_cnt + 3'd1;
                to_cnt <= '0;
                if (rx_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                    rx_byte   <= {rx_sr[6:0], sp_s2};
                end
            end else if (TO_EN && rx_cnt != 3'd0) begin
                if (to_cnt == TO_LAST) begin
                    rx_cnt <= '0;
                    rx_sr  <= '0;
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + 16'd1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
        end else begin
            rx_ovr <= 1'b0;
            if (byte_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= rx_byte;
                    rx_valid <= 1'b1;
                end else begin
                    rx_ovr <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
